// File: rtl/water_level_monitor_if.sv
// Sensor input and display/status outputs of the water level monitor.
// The monitor side uses the slave modport.
interface water_level_monitor_if #(
    parameter int N_SENS = 3
);
    logic [N_SENS-1:0] sens;
    logic [6:0]        seg;
    logic              digit;
    logic [3:0]        level;
    logic              empty;
    logic              err;
    logic              valid;

    modport master (output sens, input seg, digit, level, empty, err, valid);
    modport slave  (input sens, output seg, digit, level, empty, err, valid);
endinterface

// File: rtl/water_level_monitor.sv
// Debounced thermometer-code water level monitor with a 7-segment display,
// an empty-tank blink alarm and a fault indication.
module water_level_monitor #(
    parameter int N_SENS    = 3,
    parameter int DEB_CYC   = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    water_level_monitor_if.slave  bus
);
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {INIT, NORMAL, EMPTY, FAULT} state_t;

    logic [N_SENS-1:0] r_s1, r_s2;
    logic [DW-1:0]     r_deb;
    logic [3:0]        r_lvl;
    logic              r_valid;
    state_t            r_state, w_state_nxt;
    logic [BW-1:0]     r_blk;
    logic              r_ph;
    logic [6:0]        r_seg, w_seg;
    logic              r_digit, w_digit;
    logic [3:0]        r_level;
    logic              r_empty, w_empty;
    logic              r_err, w_err;
    logic              w_acc, w_therm;
    logic [3:0]        w_cnt;

    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        case (v)
            4'd1:    f_glyph = 7'b0110000;
            4'd2:    f_glyph = 7'b1101101;
            4'd3:    f_glyph = 7'b1111001;
            4'd4:    f_glyph = 7'b0110011;
            4'd5:    f_glyph = 7'b1011011;
            4'd6:    f_glyph = 7'b1011111;
            4'd7:    f_glyph = 7'b1110000;
            4'd8:    f_glyph = 7'b1111111;
            4'd9:    f_glyph = 7'b1111011;
            default: f_glyph = 7'b1111110;
        endcase
    endfunction

    // s2 is "unchanged" at an edge when s1 already holds the same value.
    assign w_acc   = (r_s1 == r_s2) && (r_deb == DW'(DEB_CYC - 1));
    assign w_therm = ((r_s2 & (r_s2 + N_SENS'(1))) == '0);

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N_SENS; i++)
            w_cnt = w_cnt + {3'b000, r_s2[i]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_deb   <= '0;
            r_lvl   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_s1 <= bus.sens;
            r_s2 <= r_s1;
            if (r_s1 != r_s2)
                r_deb <= '0;
            else if (r_deb != DW'(DEB_CYC - 1))
                r_deb <= r_deb + DW'(1);
            if (w_acc) begin
                r_valid <= 1'b1;
                if (w_therm)
                    r_lvl <= w_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= INIT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc)
            w_state_nxt = !w_therm ? FAULT : ((w_cnt == 4'd0) ? EMPTY : NORMAL);
        w_seg   = 7'b0000000;
        w_digit = 1'b0;
        w_empty = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            NORMAL: begin
                w_seg   = f_glyph(r_lvl);
                w_digit = 1'b1;
            end
            EMPTY: begin
                w_seg   = 7'b1111110;
                w_digit = r_ph;
                w_empty = 1'b1;
            end
            FAULT: begin
                w_seg   = 7'b1001111;
                w_digit = 1'b1;
                w_err   = 1'b1;
            end
            default: ;
        endcase
    end

    // Only a real entry into EMPTY restarts the blink; re-accepts keep phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk <= '0;
            r_ph  <= 1'b0;
        end else if (w_acc && (w_state_nxt == EMPTY) && (r_state != EMPTY)) begin
            r_blk <= '0;
            r_ph  <= 1'b1;
        end else if (r_state == EMPTY) begin
            if (r_blk == BW'(BLINK_DIV - 1)) begin
                r_blk <= '0;
                r_ph  <= ~r_ph;
            end else begin
                r_blk <= r_blk + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg   <= '0;
            r_digit <= 1'b0;
            r_level <= '0;
            r_empty <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_seg   <= w_seg;
            r_digit <= w_digit;
            r_level <= r_lvl;
            r_empty <= w_empty;
            r_err   <= w_err;
        end
    end

    assign bus.seg   = r_seg;
    assign bus.digit = r_digit;
    assign bus.level = r_level;
    assign bus.empty = r_empty;
    assign bus.err   = r_err;
    assign bus.valid = r_valid;
endmodule

// File: tb/tb_water_level_monitor.sv
// Directed and randomized checks of water_level_monitor against a
// window-based behavioural model evaluated every clock.
module tb_water_level_monitor;
    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int BD  = 8;
    localparam int S_INIT = 0, S_NORMAL = 1, S_EMPTY = 2, S_FAULT = 3;
    localparam logic [6:0] GLYPH [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101,
        7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    water_level_monitor_if #(.N_SENS(N)) bus();
    water_level_monitor #(.N_SENS(N), .DEB_CYC(DEB), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({bus.seg, bus.digit, bus.level, bus.empty, bus.err, bus.valid});
    endfunction

    // Model: a pattern is accepted at the edge where the last DEB+1 sampled
    // sens values are identical (two zero samples stand in for the reset state).
    int q[$];
    int mst = S_INIT, mlvl = 0, mes = 0, mcyc = 0;
    bit mval = 1'b0;

    initial begin
        logic [6:0] e_seg;
        logic       e_dig, e_emp, e_err;
        logic [3:0] e_lvl;
        bit         eq;
        int         p, c, nst;
        forever begin
            @(posedge clk);
            e_seg = '0; e_dig = 0; e_emp = 0; e_err = 0; e_lvl = '0;
            if (reset) begin
                q = {0, 0};
                mst = S_INIT; mlvl = 0; mes = 0; mcyc = 0; mval = 0;
            end else begin
                mcyc++;
                e_lvl = 4'(mlvl);
                case (mst)
                    S_NORMAL: begin e_seg = GLYPH[mlvl]; e_dig = 1; end
                    S_EMPTY:  begin e_seg = 7'b1111110; e_emp = 1;
                                    e_dig = (((mcyc - 1 - mes) / BD) % 2) == 0; end
                    S_FAULT:  begin e_seg = 7'b1001111; e_dig = 1; e_err = 1; end
                    default:  e_lvl = '0;
                endcase
                eq = (q.size() == DEB + 1);
                foreach (q[j]) if (q[j] != q[0]) eq = 0;
                if (eq) begin
                    p = q[$];
                    c = $countones(p);
                    mval = 1;
                    if (p == (1 << c) - 1) begin
                        mlvl = c;
                        nst = (c == 0) ? S_EMPTY : S_NORMAL;
                    end else begin
                        nst = S_FAULT;
                    end
                    if (nst == S_EMPTY && mst != S_EMPTY) mes = mcyc;
                    mst = nst;
                end
                q.push_back(int'(bus.sens));
                while (q.size() > DEB + 1) void'(q.pop_front());
            end
            #1;
            chk("outputs", outs(), int'({e_seg, e_dig, e_lvl, e_emp, e_err, mval}));
        end
    end

    task automatic hold(input logic [N-1:0] v, input int n);
        bus.sens = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        bus.sens = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 0);

        // first accept: valid on edge 6, level on edge 7
        reset = 0;
        hold(3'b011, 6);
        chk("valid_e6", int'(bus.valid), 1);
        chk("level_e6", int'(bus.level), 0);
        @(negedge clk);
        chk("level_e7", int'(bus.level), 2);
        chk("seg_2", int'(bus.seg), int'(7'b1101101));
        chk("digit_2", int'(bus.digit), 1);
        chk("err_2", int'(bus.err), 0);

        // short glitch must be rejected
        hold(3'b111, 3);
        hold(3'b011, 12);
        chk("glitch_level", int'(bus.level), 2);

        // empty alarm blink
        bus.sens = 3'b000;
        k = 0;
        while (!bus.empty && k < 20) begin @(negedge clk); k++; end
        chk("empty_latency", k, 7);
        chk("seg_0", int'(bus.seg), int'(7'b1111110));
        for (int ph = 0; ph < 3; ph++) begin
            k = 0;
            while (bus.digit == ((ph % 2) == 0) && k < 20) begin @(negedge clk); k++; end
            chk("blink_run", k, BD);
        end

        // fault holds previous level, then recovers
        hold(3'b111, 10);
        chk("level_3", int'(bus.level), 3);
        hold(3'b101, 10);
        chk("fault_err", int'(bus.err), 1);
        chk("fault_seg", int'(bus.seg), int'(7'b1001111));
        chk("fault_level", int'(bus.level), 3);
        chk("fault_digit", int'(bus.digit), 1);
        chk("fault_empty", int'(bus.empty), 0);
        hold(3'b001, 10);
        chk("rec_err", int'(bus.err), 0);
        chk("rec_level", int'(bus.level), 1);
        chk("rec_seg", int'(bus.seg), int'(7'b0110000));

        // asynchronous reset in the middle of the blink
        hold(3'b000, 12);
        #2 reset = 1;
        #1 chk("async_reset", outs(), 0);
        repeat (2) @(negedge clk);
        reset = 0;
        hold(3'b111, 6);
        chk("post_rst_e6", int'(bus.level), 0);
        @(negedge clk);
        chk("post_rst_e7", int'(bus.level), 3);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset = 1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 0;
            end
            hold(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(1, 12));
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/water_level_monitor.md
WATER_LEVEL_MONITOR -- requirements
Module: water_level_monitor

Interface
REQ-001 Parameter N_SENS, default 3, number of level sensors (legal range 1..9).
REQ-002 Parameter DEB_CYC, default 4, consecutive stable cycles required to accept a sensor pattern (>=1).
REQ-003 Parameter BLINK_DIV, default 8, half-period in clk cycles of the empty-alarm blink (>=1).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sens  input  N_SENS  raw asynchronous sensors, bit i = 1 when water reaches sensor i; bit 0 is lowest.
REQ-007 seg  output  7  7-segment drive, active-high, seg[6..0] = a,b,c,d,e,f,g.
REQ-008 digit  output  1  active-high digit enable.
REQ-009 level  output  4  accepted water level, 0..N_SENS.
REQ-010 empty  output  1  high while the accepted level is 0 and the pattern is valid.
REQ-011 err  output  1  high while the accepted pattern is not a thermometer code.
REQ-012 valid  output  1  low from reset until the first pattern is accepted, then high.

Function
REQ-013 sens SHALL pass through a two-flop synchroniser (s1, s2) before any other use.
REQ-014 Debounce: a counter SHALL clear whenever s2 differs from its previous-cycle value, otherwise increment, saturating at DEB_CYC-1.
REQ-015 The accepted pattern SHALL load s2 on the edge at which s2 is unchanged and the counter equals DEB_CYC-1; pulses shorter than DEB_CYC cycles at s2 SHALL never be accepted.
REQ-016 Valid pattern: thermometer code (all ones contiguous from bit 0, including all-zero); level = count of ones.
REQ-017 Invalid pattern (a bit set above a cleared bit): level SHALL hold its last valid value.
REQ-018 FSM states: INIT, NORMAL, EMPTY, FAULT; each accept SHALL move to FAULT if invalid, else EMPTY if level 0, else NORMAL.
REQ-019 INIT SHALL be left only by the first accept; valid SHALL rise on that same edge and stay high until reset.
REQ-020 Outputs seg, digit, level, empty and err SHALL be registered and reflect the new state one edge after the accept edge.
REQ-021 Total latency: a change held on sens from before edge 1 SHALL appear on the outputs after edge DEB_CYC+3.
REQ-022 NORMAL: digit=1 and seg = decimal glyph of level (1:bc, 2:abdeg, 3:abcdg, 4:bcfg, 5:acdfg, 6:acdefg, 7:abc, 8:abcdefg, 9:abcdfg).
REQ-023 EMPTY: seg = "0" (abcdef), empty=1, digit toggles every BLINK_DIV cycles.
REQ-024 On entry to EMPTY, the blink counter SHALL clear and digit SHALL be 1 for the first BLINK_DIV cycles.
REQ-025 FAULT: seg = "E" (adefg), digit=1 steady, err=1, empty=0.
REQ-026 INIT: seg=0, digit=0.
REQ-027 Re-accepting a pattern equal to the current one SHALL NOT restart the blink counter.
REQ-028 The blink counter SHALL wrap at BLINK_DIV-1 without dropping or repeating a cycle.

Reset
REQ-029 reset high SHALL immediately clear s1, s2, the debounce counter, the blink counter, the accepted pattern, seg, digit, level, empty, err and valid, and force INIT, without waiting for a clock edge.
REQ-030 Reset asserted mid-debounce or mid-blink SHALL discard all progress; the first post-reset accept again requires the full DEB_CYC+3 latency.

Verification (defaults N_SENS=3, DEB_CYC=4, BLINK_DIV=8)
REQ-031 Reset, then sens=3'b011 held -> after edge 7: valid=1, level=2, seg=1101101, digit=1, err=0.
REQ-032 From level 2, pulse sens=3'b111 for 3 cycles then back to 3'b011 -> outputs unchanged throughout.
REQ-033 sens=3'b000 held -> empty=1, seg=1111110; digit=1 for 8 cycles, 0 for 8 cycles, repeating.
REQ-034 sens=3'b101 held -> err=1, seg=1001111, digit=1, level holds previous value; then 3'b001 -> err=0, level=1, seg=0110000.
REQ-035 Assert reset during EMPTY blink, release, hold 3'b111 -> outputs zero during reset; level=3 exactly 7 edges after release.
